// File: rtl/mul_pkg.sv
// Shared types for the sequential shift-add multiplier.
// State encoding and external ALU opcodes.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] ALU_BYPASS = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b010;

endpackage

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier driving an external ALU.
// Optional early termination: define MUL_EARLY_TERM_EN.
module mul_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_cntrl,
  input  logic [WIDTH-1:0] alu_result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    count;
  logic             last;

`ifdef MUL_EARLY_TERM_EN
  // Remaining multiplier bits all zero: no further partial products.
  assign last = (count == LAST) || ((mplier >> 1) == '0);
`else
  assign last = (count == LAST);
`endif

  always_comb begin
    alu_cntrl = ALU_BYPASS;
    alu_a     = '0;
    alu_b     = '0;
    if (state == RUN) begin
      alu_cntrl = ALU_ADD;
      alu_a     = acc;
      alu_b     = mplier[0] ? mcand : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            acc     <= '0;
            mcand   <= multiplicand;
            mplier  <= multiplier;
            count   <= '0;
            product <= '0;
            state   <= RUN;
            busy    <= 1'b1;
          end
        end
        RUN: begin
          acc    <= alu_result;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          if (last) begin
            product <= alu_result;
            state   <= DONE;
            done    <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq with a behavioural ALU.
// Expected latencies follow MUL_EARLY_TERM_EN when defined.
module tb_mul_seq;

`ifdef MUL_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [63:0] multiplicand = '0;
  logic [63:0] multiplier = '0;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [2:0]  alu_cntrl;
  logic [63:0] alu_result;

  always #5 clk = ~clk;

  assign alu_result = (alu_cntrl == 3'b010) ? alu_a + alu_b : alu_a;

  mul_seq #(.WIDTH(64)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .multiplicand(multiplicand),
    .multiplier(multiplier),
    .busy(busy),
    .done(done),
    .product(product),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_cntrl(alu_cntrl),
    .alu_result(alu_result)
  );

  typedef struct {
    logic [63:0] p;
    int          run;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  logic [63:0] cur_a = '0;
  logic [63:0] cur_b = '0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int rc(int et_runs);
    return ET ? et_runs : 64;
  endfunction

  // Monitor: ALU drive every cycle, scoreboard pop on each done.
  int   bcnt = 0;
  bit   prev_done = 1'b0;
  exp_t e;
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy) bcnt++;
      else bcnt = 0;
      if (busy && !done) begin
        int k;
        logic [63:0] eb;
        k  = bcnt - 1;
        eb = (k >= 0 && k < 64 && cur_b[k]) ? (cur_a << k) : 64'd0;
        chk("run_cntrl", {61'd0, alu_cntrl}, 64'd2);
        chk("run_alu_b", alu_b, eb);
      end else begin
        chk("idle_cntrl", {61'd0, alu_cntrl}, 64'd0);
        chk("idle_alu_a", alu_a, 64'd0);
        chk("idle_alu_b", alu_b, 64'd0);
      end
      if (done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 required no pulse");
        end else begin
          e = q.pop_front();
          chk("product", product, e.p);
          chk("busy_cycles", 64'(bcnt), 64'(e.run + 1));
        end
      end
      if (prev_done) chk("done_pulse_len", {63'd0, done}, 64'd0);
      prev_done = done;
    end
  end

  task automatic issue(logic [63:0] a, logic [63:0] b,
                       logic [63:0] p, int run, bit push);
    @(posedge clk); #1;
    start        = 1'b1;
    multiplicand = a;
    multiplier   = b;
    cur_a        = a;
    cur_b        = b;
    if (push) q.push_back('{p, run});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 300);
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL timeout: busy still 1 after %0d cycles", n);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_product", product, 64'd0);
    chk("rst_cntrl", {61'd0, alu_cntrl}, 64'd0);
    @(posedge clk); #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    issue(64'd3, 64'd5, 64'd15, rc(3), 1'b1);
    wait_idle();
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
          64'hFFFF_FFFF_FFFF_FFFE, rc(2), 1'b1);
    wait_idle();
    issue(64'h1_0000_0001, 64'h1_0000_0001,
          64'h2_0000_0001, rc(33), 1'b1);
    wait_idle();

    // Start during RUN must be ignored
    issue(64'd7, 64'd6, 64'd42, rc(3), 1'b1);
    repeat (ET ? 1 : 8) @(posedge clk);
    #1;
    start        = 1'b1;
    multiplicand = 64'd1;
    multiplier   = 64'd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    // Abort mid-RUN with reset
    issue(64'd2, 64'h8000_0000_0000_0003, 64'd0, 64, 1'b0);
    repeat (29) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_product", product, 64'd0);
    chk("abort_cntrl", {61'd0, alu_cntrl}, 64'd0);
    issue(64'd2, 64'd2, 64'd4, rc(2), 1'b1);
    wait_idle();

    // Reset and start together: reset wins
    @(posedge clk); #1;
    reset        = 1'b1;
    start        = 1'b1;
    multiplicand = 64'd5;
    multiplier   = 64'd5;
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("rst_start_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    chk("rst_start_busy2", {63'd0, busy}, 64'd0);

    issue(64'd9, 64'd5, 64'd45, rc(3), 1'b1);
    wait_idle();
    issue(64'd9, 64'd0, 64'd0, rc(1), 1'b1);
    wait_idle();
    repeat (3) @(negedge clk);

    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
